// File: rtl/gj_pkg.sv
// Shared definitions for the Gauss-Jordan inversion block: matrix order,
// element width, row-op encoding, sequencer states and the row-op command.
package gj_pkg;

  localparam int GJ_N  = 5;
  localparam int GJ_W  = 8;
  localparam int GJ_RW = $clog2(GJ_N);

  typedef enum logic {
    OP_ADD  = 1'b0,
    OP_ELIM = 1'b1
  } op_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_PIV,
    S_WAIT,
    S_CHECK,
    S_SRCH_RD,
    S_SRCH_WAIT,
    S_SRCH_CHK,
    S_ISSUE_ADD,
    S_ELIM_SEL,
    S_ISSUE_ELIM,
    S_NEXT,
    S_SINGULAR,
    S_FINISH
  } state_e;

  typedef struct packed {
    op_e              op;
    logic [GJ_RW-1:0] dst;
    logic [GJ_RW-1:0] src;
  } cmd_t;

endpackage

// File: rtl/gj_inv_sequencer.sv
// Gauss-Jordan inversion control sequencer: walks pivots, fixes zero
// pivots with a row-add from a lower row, issues one ELIM per non-pivot
// row, and reports done/singular.
// Ports: clk, rst (async high), start, busy, done, singular, pivot,
//        rd_row/rd_col/rd_data (1-cycle registered read port),
//        cmd_valid/cmd_ready handshake with cmd_op/cmd_dst/cmd_src.
module gj_inv_sequencer
  import gj_pkg::*;
#(
  parameter int N  = GJ_N,
  parameter int W  = GJ_W,
  parameter int RW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          singular,
  output logic [RW-1:0] pivot,
  output logic [RW-1:0] rd_row,
  output logic [RW-1:0] rd_col,
  input  logic [W-1:0]  rd_data,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic          cmd_op,
  output logic [RW-1:0] cmd_dst,
  output logic [RW-1:0] cmd_src
);

  localparam logic [RW-1:0] LAST = RW'(N - 1);

  state_e        r_state, w_state;
  logic [RW-1:0] r_pivot, w_pivot;
  // Row cursor: elimination row in ELIM_*, search row in SRCH_*.
  logic [RW-1:0] r_row, w_row;
  logic [RW-1:0] r_rd_row, w_rd_row;
  logic [RW-1:0] r_rd_col, w_rd_col;
  logic          r_valid, w_valid;
  op_e           r_op, w_op;
  logic [RW-1:0] r_dst, w_dst;
  logic [RW-1:0] r_src, w_src;
  logic          r_busy, w_busy;
  logic          r_done, w_done;
  logic          r_sing, w_sing;
  logic          w_nz;

  assign w_nz = (rd_data != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pivot  <= '0;
      r_row    <= '0;
      r_rd_row <= '0;
      r_rd_col <= '0;
      r_valid  <= 1'b0;
      r_op     <= OP_ADD;
      r_dst    <= '0;
      r_src    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sing   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_pivot  <= w_pivot;
      r_row    <= w_row;
      r_rd_row <= w_rd_row;
      r_rd_col <= w_rd_col;
      r_valid  <= w_valid;
      r_op     <= w_op;
      r_dst    <= w_dst;
      r_src    <= w_src;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_sing   <= w_sing;
    end
  end

  // Outputs are registered, so every field is set on the edge that
  // enters the state that needs it and is held stable afterwards.
  always_comb begin
    w_state  = r_state;
    w_pivot  = r_pivot;
    w_row    = r_row;
    w_rd_row = r_rd_row;
    w_rd_col = r_rd_col;
    w_valid  = r_valid;
    w_op     = r_op;
    w_dst    = r_dst;
    w_src    = r_src;
    w_busy   = r_busy;
    w_done   = 1'b0;
    w_sing   = r_sing;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state  = S_RD_PIV;
          w_pivot  = '0;
          w_sing   = 1'b0;
          w_busy   = 1'b1;
          w_rd_row = '0;
          w_rd_col = '0;
        end
      end
      S_RD_PIV: w_state = S_WAIT;
      S_WAIT:   w_state = S_CHECK;
      S_CHECK: begin
        if (w_nz) begin
          w_row   = '0;
          w_state = S_ELIM_SEL;
        end else if (r_pivot == LAST) begin
          w_state = S_SINGULAR;
        end else begin
          w_row    = r_pivot + 1'b1;
          w_rd_row = r_pivot + 1'b1;
          w_rd_col = r_pivot;
          w_state  = S_SRCH_RD;
        end
      end
      S_SRCH_RD:   w_state = S_SRCH_WAIT;
      S_SRCH_WAIT: w_state = S_SRCH_CHK;
      S_SRCH_CHK: begin
        if (w_nz) begin
          w_valid = 1'b1;
          w_op    = OP_ADD;
          w_dst   = r_pivot;
          w_src   = r_row;
          w_state = S_ISSUE_ADD;
        end else if (r_row == LAST) begin
          w_state = S_SINGULAR;
        end else begin
          w_row    = r_row + 1'b1;
          w_rd_row = r_row + 1'b1;
          w_state  = S_SRCH_RD;
        end
      end
      S_ISSUE_ADD: begin
        if (cmd_ready) begin
          // Pivot row changed: re-read it before eliminating.
          w_valid  = 1'b0;
          w_rd_row = r_pivot;
          w_rd_col = r_pivot;
          w_state  = S_RD_PIV;
        end
      end
      S_ELIM_SEL: begin
        if (r_row == r_pivot) begin
          if (r_row == LAST) begin
            w_state = S_NEXT;
          end else begin
            w_row = r_row + 1'b1;
          end
        end else begin
          w_valid = 1'b1;
          w_op    = OP_ELIM;
          w_dst   = r_row;
          w_src   = r_pivot;
          w_state = S_ISSUE_ELIM;
        end
      end
      S_ISSUE_ELIM: begin
        if (cmd_ready) begin
          w_valid = 1'b0;
          if (r_row == LAST) begin
            w_state = S_NEXT;
          end else begin
            w_row   = r_row + 1'b1;
            w_state = S_ELIM_SEL;
          end
        end
      end
      S_NEXT: begin
        if (r_pivot == LAST) begin
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_state = S_FINISH;
        end else begin
          w_pivot  = r_pivot + 1'b1;
          w_rd_row = r_pivot + 1'b1;
          w_rd_col = r_pivot + 1'b1;
          w_state  = S_RD_PIV;
        end
      end
      S_SINGULAR: begin
        w_sing  = 1'b1;
        w_busy  = 1'b0;
        w_done  = 1'b1;
        w_state = S_FINISH;
      end
      S_FINISH: w_state = S_IDLE;
      default:  w_state = S_IDLE;
    endcase
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign singular  = r_sing;
  assign pivot     = r_pivot;
  assign rd_row    = r_rd_row;
  assign rd_col    = r_rd_col;
  assign cmd_valid = r_valid;
  assign cmd_op    = r_op;
  assign cmd_dst   = r_dst;
  assign cmd_src   = r_src;

endmodule

// File: tb/tb_gj_inv_sequencer.sv
// Directed bench for gj_inv_sequencer with a behavioural row-op
// datapath and registered matrix read port.
module tb_gj_inv_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, singular;
  logic [2:0] pivot, rd_row, rd_col;
  logic [7:0] rd_data;
  logic       cmd_valid;
  logic       cmd_ready = 1'b0;
  logic       cmd_op;
  logic [2:0] cmd_dst, cmd_src;
  logic [19:0] outs;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem  [5][5];
  logic [7:0] tmat [5][5];
  logic       load_req = 1'b0;
  int         rdy_mode = 1;
  logic [6:0] got [$];
  logic [6:0] exp_q [$];
  int         stall_bad = 0;
  int         stall_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [6:0] prev_f = '0;
  logic [7:0] a_v, b_v;

  gj_inv_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done), .singular(singular),
    .pivot(pivot), .rd_row(rd_row), .rd_col(rd_col),
    .rd_data(rd_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src)
  );

  assign outs = {busy, done, singular, pivot, rd_row, rd_col,
                 cmd_valid, cmd_op, cmd_dst, cmd_src};

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_row][rd_col];

  // Datapath model plus stall-stability monitor.
  always @(negedge clk) begin
    if (load_req) mem = tmat;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (cmd_valid !== 1'b1 ||
          {cmd_op, cmd_dst, cmd_src} !== prev_f))
        stall_bad++;
      if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
        got.push_back({cmd_op, cmd_dst, cmd_src});
        if (cmd_op) begin
          a_v = mem[cmd_src][pivot];
          b_v = mem[cmd_dst][pivot];
          for (int j = 0; j < 5; j++)
            mem[cmd_dst][j] = mem[cmd_dst][j] * a_v
                            - mem[cmd_src][j] * b_v;
        end else begin
          for (int j = 0; j < 5; j++)
            mem[cmd_dst][j] = mem[cmd_dst][j] + mem[cmd_src][j];
        end
      end
      prev_stall = cmd_valid && !cmd_ready;
      if (prev_stall) stall_cnt++;
      prev_f = {cmd_op, cmd_dst, cmd_src};
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cmd_ready = (rdy_mode == 1) ||
                  (rdy_mode == 2 && $urandom_range(0, 99) < 30);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_ident();
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        tmat[i][j] = (i == j) ? 8'd1 : 8'd0;
  endtask

  task automatic load();
    load_req = 1'b1;
    @(negedge clk);
    #1 load_req = 1'b0;
  endtask

  task automatic exp_elims(input int np);
    for (int p = 0; p < np; p++)
      for (int r = 0; r < 5; r++)
        if (r != p) exp_q.push_back({1'b1, 3'(r), 3'(p)});
  endtask

  task automatic cmp_seq(input string tag, input int base);
    chk({tag, "_count"}, got.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < got.size())
        chk($sformatf("%s_cmd%0d", tag, i), got[base + i], exp_q[i]);
  endtask

  task automatic run(input int budget, input int pulse_at,
                     output int cyc);
    int ovl;
    ovl = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("first_rd_addr", {rd_row, rd_col}, 0);
    cyc = 0;
    while (done !== 1'b1 && cyc < budget) begin
      start = (cyc == pulse_at);
      @(posedge clk);
      #1;
      cyc++;
      if (busy === 1'b1 && done === 1'b1) ovl++;
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    chk("busy_low_at_done", busy, 0);
    chk("no_busy_done_overlap", ovl, 0);
  endtask

  initial begin
    int base, cyc, sb0, sc0, n;

    set_ident();
    mem = tmat;
    repeat (2) @(posedge clk);
    #1 chk("reset_outputs", outs, 0);
    @(negedge clk) rst = 1'b0;

    // Identity, ready high.
    set_ident();
    load();
    base = got.size();
    run(300, -1, cyc);
    chk("id_cycles", cyc, 65);
    chk("id_singular", singular, 0);
    exp_q.delete();
    exp_elims(5);
    cmp_seq("id", base);

    // Zero pivots fixed by row-adds at p0 and p1.
    set_ident();
    tmat[0] = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd0};
    tmat[1] = '{8'd0, 8'd0, 8'd1, 8'd0, 8'd0};
    tmat[2] = '{8'd3, 8'd0, 8'd0, 8'd0, 8'd0};
    load();
    base = got.size();
    run(300, -1, cyc);
    chk("add_cycles", cyc, 82);
    chk("add_singular", singular, 0);
    exp_q.delete();
    for (int p = 0; p < 5; p++) begin
      if (p < 2) exp_q.push_back({1'b0, 3'(p), 3'd2});
      for (int r = 0; r < 5; r++)
        if (r != p) exp_q.push_back({1'b1, 3'(r), 3'(p)});
    end
    cmp_seq("add", base);

    // Column 0 all zero.
    set_ident();
    tmat[0][0] = 8'd0;
    load();
    base = got.size();
    run(100, -1, cyc);
    chk("col0_cycles", cyc, 16);
    chk("col0_singular", singular, 1);
    chk("col0_no_cmds", got.size() - base, 0);

    // Last pivot zero: no rows left to search.
    set_ident();
    tmat[4][4] = 8'd0;
    load();
    base = got.size();
    run(300, -1, cyc);
    chk("last_cycles", cyc, 56);
    chk("last_singular", singular, 1);
    exp_q.delete();
    exp_elims(4);
    cmp_seq("last", base);

    // Random ready.
    set_ident();
    load();
    chk("singular_held", singular, 1);
    rdy_mode = 2;
    sb0 = stall_bad;
    sc0 = stall_cnt;
    base = got.size();
    run(3000, -1, cyc);
    rdy_mode = 1;
    chk("rnd_singular", singular, 0);
    exp_q.delete();
    exp_elims(5);
    cmp_seq("rnd", base);
    chk("rnd_stall_stable", stall_bad - sb0, 0);
    chk("rnd_stall_seen", (stall_cnt > sc0), 1);

    // start pulsed while busy.
    set_ident();
    load();
    base = got.size();
    run(300, 20, cyc);
    chk("busy_start_cycles", cyc, 65);
    cmp_seq("busy_start", base);

    // Reset mid-search.
    set_ident();
    tmat[0][0] = 8'd0;
    load();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("srch_addr", {rd_row, rd_col}, {3'd1, 3'd0});
    #1 rst = 1'b1;
    #1 chk("rst_mid_search", outs, 0);
    @(negedge clk) rst = 1'b0;

    // Reset mid-stall.
    set_ident();
    rdy_mode = 0;
    load();
    base = got.size();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (cmd_valid !== 1'b1 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1 chk("stall_fields", {cmd_valid, cmd_op, cmd_dst, cmd_src},
           8'b1_1_001_000);
    #1 rst = 1'b1;
    #1 chk("rst_mid_stall", outs, 0);
    chk("stall_no_xfer", got.size() - base, 0);
    @(negedge clk) rst = 1'b0;
    rdy_mode = 1;

    // Clean run after reset.
    load();
    base = got.size();
    run(300, -1, cyc);
    chk("post_rst_cycles", cyc, 65);
    chk("post_rst_singular", singular, 0);
    cmp_seq("post_rst", base);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
